// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, SubBytes FSM encoding, byte offsets and S-box tables.
// The inverse table is only built when SUB_BYTES_INV_EN is defined.
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  // Byte 0 is the most significant byte (column-major AES order)
  function automatic int byte_off(input int i);
    return STATE_W - 1 - BYTE_W * i;
  endfunction

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef SUB_BYTES_INV_EN
  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
`endif

endpackage

// File: rtl/sub_bytes_lane.sv
// One SubBytes lane: byte in, substituted byte out.
// With SUB_BYTES_INV_EN the lane also carries the inverse S-box, chosen by inv.
module sub_bytes_lane
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] din,
`ifdef SUB_BYTES_INV_EN
  input  logic              inv,
`endif
  output logic [BYTE_W-1:0] dout
);

`ifdef SUB_BYTES_INV_EN
  always_comb dout = inv ? SBOX_INV[din] : SBOX_FWD[din];
`else
  assign dout = SBOX_FWD[din];
`endif

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: LANES bytes substituted per cycle, 16/LANES cycles per state.
// Optional inverse substitution selected per block when SUB_BYTES_INV_EN is defined.
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
`ifdef SUB_BYTES_INV_EN
  input  logic               in_inv,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy
);

  localparam int NCYC  = 16 / LANES;
  localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

  fsm_e               state_q, state_d;
  logic [STATE_W-1:0] st_q, st_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               accept;
`ifdef SUB_BYTES_INV_EN
  logic               inv_q, inv_d;
`endif

  logic [BYTE_W-1:0] lane_in  [LANES];
  logic [BYTE_W-1:0] lane_out [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_in[g] = st_q[byte_off(int'(cnt_q) * LANES + g) -: BYTE_W];
    sub_bytes_lane u_lane (
      .din  (lane_in[g]),
`ifdef SUB_BYTES_INV_EN
      .inv  (inv_q),
`endif
      .dout (lane_out[g])
    );
  end

  // Combinational from state and out_ready only, so upstream may wait on it
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    cnt_d   = cnt_q;
`ifdef SUB_BYTES_INV_EN
    inv_d   = inv_q;
`endif
    unique case (state_q)
      IDLE: ;
      RUN: begin
        for (int l = 0; l < LANES; l++)
          st_d[byte_off(int'(cnt_q) * LANES + l) -: BYTE_W] = lane_out[l];
        if (cnt_q == CNT_W'(NCYC - 1)) state_d = DONE;
        else                           cnt_d   = cnt_q + CNT_W'(1);
      end
      DONE: if (out_ready && !in_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Acceptance overrides the above, covering both IDLE and the DONE hand-over
    if (accept) begin
      st_d    = in_state;
      cnt_d   = '0;
      state_d = RUN;
`ifdef SUB_BYTES_INV_EN
      inv_d   = in_inv;
`endif
    end
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      st_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SUB_BYTES_INV_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef SUB_BYTES_INV_EN
      inv_q       <= inv_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_state = st_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed self-checking bench for sub_bytes_iter with LANES=4.
module tb_sub_bytes_iter;

  localparam int NCYC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
`ifdef SUB_BYTES_INV_EN
  logic         in_inv;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sub_bytes_iter #(.LANES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
`ifdef SUB_BYTES_INV_EN
    .in_inv    (in_inv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  // Accept one state, follow it through RUN to DONE, and let it drain with out_ready=1
  task automatic run_block(input string tag, input logic [127:0] s, input logic [127:0] exp);
    @(negedge clk);
    in_state = s;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    chk({tag, "_busy0"}, busy, 1);
    for (int k = 1; k <= NCYC; k++) begin
      @(posedge clk); #1;
      chk($sformatf("%s_valid_e%0d", tag, k), out_valid, (k == NCYC));
      chk($sformatf("%s_busy_e%0d", tag, k), busy, 1);
    end
    chk({tag, "_data"}, out_state, exp);
    @(posedge clk); #1;
    chk({tag, "_drain_valid"}, out_valid, 0);
    chk({tag, "_drain_busy"}, busy, 0);
  endtask

  logic [127:0] bb_s [3];
  logic [127:0] bb_e [3];
  int           t_out [3];

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_state  = '0;
    out_ready = 1'b1;
`ifdef SUB_BYTES_INV_EN
    in_inv    = 1'b0;
`endif
    // Handshake attempted while in reset must be ignored
    @(negedge clk);
    in_valid = 1'b1;
    in_state = {16{8'h5A}};
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_state", out_state, '0);
    in_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);

    run_block("zero", '0, {16{8'h63}});
    run_block("fips", 128'h00112233445566778899AABBCCDDEEFF,
              128'h638293C31BFC33F5C4EEACEA4BC12816);

    // Backpressure: second block waits while first is held
    out_ready = 1'b0;
    @(negedge clk);
    in_state = 128'h00112233445566778899AABBCCDDEEFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 20 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    chk("bp_first_valid", out_valid, 1);
    @(negedge clk);
    in_state = {16{8'h23}};
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold_valid%0d", k), out_valid, 1);
      chk($sformatf("bp_hold_data%0d", k), out_state, 128'h638293C31BFC33F5C4EEACEA4BC12816);
      chk($sformatf("bp_hold_rdy%0d", k), in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_comb", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept_valid", out_valid, 0);
    chk("bp_accept_busy", busy, 1);
    repeat (NCYC) @(posedge clk);
    #1;
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_data", out_state, {16{8'h26}});
    @(posedge clk); #1;
    chk("bp_drain", out_valid, 0);

    // Back-to-back with out_ready held high
    bb_s[0] = {16{8'h23}}; bb_e[0] = {16{8'h26}};
    bb_s[1] = {16{8'h56}}; bb_e[1] = {16{8'hB1}};
    bb_s[2] = {16{8'hA3}}; bb_e[2] = {16{8'h0A}};
    @(negedge clk);
    in_state = bb_s[0];
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i < 2) in_state = bb_s[i+1];
      else       in_valid = 1'b0;
      repeat (NCYC - 1) @(posedge clk);
      #1;
      chk($sformatf("b2b_early%0d", i), out_valid, 0);
      @(posedge clk); #1;
      chk($sformatf("b2b_valid%0d", i), out_valid, 1);
      chk($sformatf("b2b_data%0d", i), out_state, bb_e[i]);
      t_out[i] = cyc;
    end
    chk("b2b_gap01", t_out[1] - t_out[0], 5);
    chk("b2b_gap12", t_out[2] - t_out[1], 5);
    @(posedge clk); #1;
    chk("b2b_drain", out_valid, 0);

    // Reset in the middle of RUN discards the block
    @(negedge clk);
    in_state = {16{8'hA3}};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rdy", in_ready, 1);
    chk("mid_rst_state", out_state, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_rst_no_out", out_valid, 0);
    run_block("after_rst", {16{8'hFF}}, {16{8'h16}});

`ifdef SUB_BYTES_INV_EN
    in_inv = 1'b1;
    run_block("inv", {16{8'h63}}, '0);
    in_inv = 1'b0;
    run_block("fwd_after_inv", {16{8'h53}}, {16{8'hED}});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sub_bytes_iter.md
# sub_bytes_iter

Iterative AES SubBytes stage. Accepts one 128-bit AES state through a valid/ready handshake, passes every byte through the S_box substitution LANES bytes per cycle, and presents the substituted state through a second valid/ready handshake. Sits in the round datapath between AddRoundKey (upstream) and ShiftRows (downstream). It trades throughput for area: LANES S-box instances instead of sixteen.

## Interface
- LANES, 4: S-box instances, equal to bytes substituted per cycle; legal values 1, 2, 4, 8, 16; NCYC = 16/LANES.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream state available.
- in_ready  out  1  block can accept a state.
- in_state  in  128  input state; byte i = in_state[127-8i -: 8], i=0..15 (column-major AES order).
- in_inv  in  1  select inverse S-box for this block; present only with SUB_BYTES_INV_EN.
- out_valid  out  1  substituted state available.
- out_ready  in  1  downstream accepts.
- out_state  out  128  substituted state, same byte order.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Working register st[127:0], counter cnt of width clog2(NCYC), minimum 1 bit.
- IDLE: in_ready=1. On in_valid: st<=in_state, cnt<=0, go to RUN.
- RUN: bytes cnt*LANES .. cnt*LANES+LANES-1 of st replaced by S_box(byte); other bytes hold. When cnt==NCYC-1, go to DONE. Otherwise cnt<=cnt+1.
- DONE: out_valid=1, out_state=st, held stable until accepted.
  - out_ready=1 and in_valid=1: accept the next state in the same cycle (st<=in_state, cnt<=0, go to RUN).
  - out_ready=1 and in_valid=0: go to IDLE.
- in_ready = (IDLE) or (DONE and out_ready). It is combinational from the state and out_ready, and never depends on in_valid.
- in_state is sampled only on the acceptance edge. Later changes have no effect.
- in_valid is ignored in RUN. Upstream holds it asserted, and the state is not lost.
- Reset (async, any state, including mid-RUN): FSM=IDLE, cnt=0, st=0. The in-flight block is discarded and is not output.
  - Outputs during and after reset: out_valid=0, busy=0, out_state=0, in_ready=1.
  - Handshakes while rst is high are ignored.

## Timing
- Acceptance on edge T: out_valid rises after edge T+NCYC. With LANES=4, it is high in the cycle after the 4th post-accept edge.
- Throughput with out_ready held high: one block per NCYC+1 cycles.
- Latency is independent of data and of in_inv.
- out_valid, out_state and busy are registered. in_ready has one combinational path from out_ready.

## Configuration
- SUB_BYTES_INV_EN defined:
  - Port in_inv exists, and each lane also instantiates the inverse S-box.
  - in_inv is captured with the state at acceptance. Substitution for that block uses the inverse table when in_inv=1.
- SUB_BYTES_INV_EN undefined: no in_inv port and no inverse S-box logic. Forward substitution only.

## Structure
- Shared package aes_pkg holds:
  - the state width constant (128) and byte width (8);
  - the FSM state encoding (IDLE=0, RUN=1, DONE=2);
  - a byte-index helper function returning the bit offset 127-8i.
- One sub-module, sub_bytes_lane. It wraps one S_box instance (plus the inverse S-box under SUB_BYTES_INV_EN) with the inv select, and maps 8 bits in to 8 bits out. It is instantiated LANES times via a generate loop.

## Test plan
- Reset, then in_state=128'h0 with out_ready=1 (LANES=4) -> out_state = 16×0x63; out_valid high exactly after the 4th edge post-accept; busy high throughout.
- in_state=128'h00112233445566778899AABBCCDDEEFF -> out_state=128'h638293C31BFC33F5C4EEACEA4BC12816.
- Backpressure: out_ready=0 for 5 cycles after out_valid, second in_valid held -> out_state stable, in_ready=0, no second accept; then out_ready=1 -> second block accepted the same cycle and output correctly.
- Back-to-back: three states (bytes 0x23, 0x56, 0xA3 replicated), out_ready=1 -> outputs 16×0x26, 16×0xB1, 16×0x0A, spaced 5 cycles apart.
- rst pulsed on the 2nd RUN cycle -> out_valid=0, busy=0, in_ready=1 immediately; the next block of 16×0xFF gives 16×0x16 with normal latency.
- SUB_BYTES_INV_EN: in_inv=1, state of 16×0x63 -> 16×0x00. The following block with in_inv=0 and 16×0x53 -> 16×0xED.
